demux_1to4: RTL
===============

# demux_1to4

Registered 1:4 stream demultiplexer with valid/ready handshaking. It is the fan-out counterpart to the catalog's 4:1 mux. An N-bit input word is steered by a 2-bit select to one of four output channels a/b/c/d. Each channel holds the word in a one-entry output register until its consumer accepts it. The block sits between a single producer and four independent consumers and gives per-channel back-pressure.

## Interface
Parameters:
- N, default 8: data width of the input and of every output channel.

Ports:
- clk  input  1  rising-edge clock; all state updates on this edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  enable; when low, no new input is accepted.
- sel  input  2  channel select: 00→a, 01→b, 10→c, 11→d; sampled only on an accepted transfer.
- din  input  N  input data word.
- din_valid  input  1  producer has a word on din.
- din_ready  output  1  block can accept din this cycle.
- y_a, y_b, y_c, y_d  output  N each  channel output registers.
- y_valid  output  4  per-channel valid; bit 0=a … bit 3=d.
- y_ready  input  4  per-channel consumer ready; bit 0=a … bit 3=d.
- xfer_cnt  output  32  present only with DEMUX_CNT_EN; four 8-bit counters, [7:0]=a … [31:24]=d.

## Operation
- Each channel k has a data register y_k and a flag y_valid[k].
- din_ready = en & (~y_valid[sel] | y_ready[sel]). This is combinational from en, sel, y_valid and y_ready.
- Input accept: din_valid & din_ready. On accept, y_sel ← din and y_valid[sel] ← 1.
- Output drain: y_valid[k] & y_ready[k]. On drain with no simultaneous load to k, y_valid[k] ← 0. y_k keeps its last value.
- Load and drain on the same channel in the same cycle: the new word replaces the old one and y_valid[k] stays 1. Full throughput on one channel is therefore one word per cycle.
- Non-selected channels drain independently every cycle, whatever en, sel or din_valid are doing.
- When en=0, din_ready=0 and nothing is loaded. Channels still drain.
- sel may change on any cycle. Only its value in the accept cycle matters. The block holds no sticky routing state.
- A word is never dropped or duplicated. A channel register is overwritten only when it is empty or is draining in the same cycle.

## Timing
- Reset, asynchronous while rst=1: y_a..y_d = 0, y_valid = 4'b0000, xfer_cnt = 0. din_ready follows its equation (1 if en=1, since all channels are empty).
- Latency: a word accepted on edge t appears on y_sel with y_valid[sel]=1 immediately after edge t. It is visible in cycle t+1.
- A word holds stable on y_k with y_valid[k]=1 until the edge at which y_ready[k]=1.
- Reset asserted mid-transfer: all pending words are discarded and all valids clear immediately. After deassertion, the first accept is possible on the first clk edge.
- No combinational path from din to any y output. The only combinational path from y_ready to din_ready is the single channel selected by sel.

## Configuration
- DEMUX_CNT_EN defined: adds the xfer_cnt port. Each 8-bit counter increments by 1 on every drain of its channel. It wraps from 255 to 0 and resets to 0.
- DEMUX_CNT_EN undefined: the xfer_cnt port and all counter logic are absent. All other behaviour is identical.

## Test plan
- Reset: hold rst=1 with en=1 → y_valid=0000, y_a..y_d=0, din_ready=1. Assert rst mid-stream → y_valid=0000 at once.
- Routing: N=8, y_ready=1111, en=1. Send din=8'hA5 with sel=00, 8'h5A with sel=01, 8'hAA with sel=10, 8'hF0 with sel=11 on consecutive cycles → each value appears on y_a, y_b, y_c, y_d respectively one cycle later. Its valid bit is high for exactly one cycle.
- Back-pressure:
  - y_ready=0000; send 8'h11 to channel b → y_b=8'h11 and y_valid[1] held.
  - Next word with sel=01 → din_ready=0 and y_b is unchanged.
  - Set y_ready[1]=1 → the next word (8'h22) is loaded the same cycle. y_valid[1] stays 1 and y_b=8'h22 the following cycle.
- Independence: channel a stalled full. A word for sel=10 is still accepted, and y_valid[2]=1 the next cycle.
- Enable: en=0, din_valid=1 for 5 cycles → din_ready=0 and no channel loads. Pending channels drain normally.
- Counters (DEMUX_CNT_EN): push 257 words to channel d with y_ready[3]=1 → xfer_cnt[31:24]=1 and the other counters are 0.

Source files
------------

// File: rtl/demux_1to4.sv
// Registered 1:4 stream demultiplexer: din is steered by sel into one of four
// one-entry output registers with per-channel back-pressure. Optional per-channel
// drain counters on xfer_cnt are built only when DEMUX_CNT_EN is defined.
module demux_1to4 #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [1:0]   sel,
  input  logic [N-1:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic [N-1:0] y_a,
  output logic [N-1:0] y_b,
  output logic [N-1:0] y_c,
  output logic [N-1:0] y_d,
  output logic [3:0]   y_valid,
`ifdef DEMUX_CNT_EN
  output logic [31:0]  xfer_cnt,
`endif
  input  logic [3:0]   y_ready
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both 1; valid never waits on ready, and a held word stays stable until taken.
  logic [N-1:0] y_q [4];
  logic [3:0]   load;
  logic [3:0]   drain;
  logic         accept;

  // Only the selected channel's occupancy gates the input, so a stalled
  // channel never blocks traffic to the others.
  assign din_ready = en & (~y_valid[sel] | y_ready[sel]);
  assign accept    = din_valid & din_ready;

  always_comb begin
    load = 4'b0000;
    if (accept) load[sel] = 1'b1;
    drain = y_valid & y_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_valid <= 4'b0000;
      for (int k = 0; k < 4; k++) y_q[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (load[k]) begin
          y_q[k]     <= din;
          y_valid[k] <= 1'b1;
        end else if (drain[k]) begin
          y_valid[k] <= 1'b0;
        end
      end
    end
  end

  assign y_a = y_q[0];
  assign y_b = y_q[1];
  assign y_c = y_q[2];
  assign y_d = y_q[3];

`ifdef DEMUX_CNT_EN
  logic [7:0] cnt [4];

  // Counters wrap naturally at 8 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) cnt[k] <= 8'd0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (drain[k]) cnt[k] <= cnt[k] + 8'd1;
      end
    end
  end

  assign xfer_cnt = {cnt[3], cnt[2], cnt[1], cnt[0]};
`endif

endmodule
